param_counter: RTL and testbench
================================

Name: param_counter

Overview:
Parametrised next-generation counter: configurable width and terminal value, up/down counting, parallel load, synchronous clear, and wrap or saturate mode. Provides registered full/empty flags, a terminal-event pulse and sticky overflow/underflow flags. Used as the generic event/occupancy counter in datapath and control blocks wherever a fixed 4-bit full-detect counter was used before.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX, 2**WIDTH-1, terminal count value; legal range 1..2**WIDTH-1
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries
PRESCALE, 4, enabled cycles per count step (used only with the optional feature; legal range >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
clr  input  1  synchronous clear of count, flags and sticky bits
ld  input  1  parallel load strobe
ld_val  input  WIDTH  load value
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
cnt  output  WIDTH  current count (registered)
full  output  1  cnt == MAX
empty  output  1  cnt == 0
tc  output  1  one-cycle pulse: boundary event occurred on previous edge
ovf  output  1  sticky: increment attempted at MAX
unf  output  1  sticky: decrement attempted at 0

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: cnt=0, full=0 (or 1 if MAX==0, which is illegal), empty=1, tc=0, ovf=0, unf=0.
- Priority per edge: rst > clr > ld > en. clr has the same effect as rst on all state.
- ld: cnt <= min(ld_val, MAX). Values above MAX are clamped, never stored. tc is not asserted. Sticky bits are unaffected.
- en && up, cnt<MAX: cnt <= cnt+1.
- en && up, cnt==MAX: SATURATE=0 gives cnt <= 0; SATURATE=1 holds cnt. In both modes ovf <= 1 and tc pulses the next cycle.
- en && !up, cnt>0: cnt <= cnt-1.
- en && !up, cnt==0: SATURATE=0 gives cnt <= MAX; SATURATE=1 holds cnt. In both modes unf <= 1 and tc pulses the next cycle.
- !en, no ld: everything holds and tc <= 0.
- Latency: cnt updates at the edge after the inputs are sampled. full and empty are combinational decodes of the registered cnt, so they are valid in the same cycle as cnt. tc is a registered pulse, high for exactly one cycle after the edge that hit the boundary.
- Arithmetic is done at WIDTH+1 bits internally with no implicit truncation. With MAX < 2**WIDTH-1, cnt never exceeds MAX.
- Simultaneous ld and en: ld wins and the count step is discarded.
- Reset or clr asserted mid-sequence: everything returns to reset values at that edge; any pending tc is cancelled.

Optional Feature:
Macro PARAM_COUNTER_PRESCALE_EN.
- Defined: an internal prescaler (width $clog2(PRESCALE)) counts enabled cycles. A count step, with all of the boundary behaviour above, occurs only on every PRESCALE-th enabled cycle. Cycles with en=0 do not advance the prescaler. The prescaler resets on rst, clr and ld. Direction is sampled on the stepping cycle.
- Undefined: no prescaler logic; a step occurs on every enabled cycle and PRESCALE is ignored.

Decomposition:
- Package param_counter_pkg holds:
  - the mode enum (MODE_WRAP, MODE_SAT) used for SATURATE;
  - a function clamp_val(val, max);
  - localparam checks: MAX range, WIDTH>=2, PRESCALE>=2.
- One sub-module, count_bound_detect: combinational, takes cnt and MAX, outputs at_max and at_zero. It drives full and empty and feeds the next-state logic.

Test Plan:
1. WIDTH=4, MAX=9, SATURATE=0: rst, then 10 cycles of en=1 up=1 -> cnt 1..9 then 0; tc=1 on the cycle after cnt 9->0; ovf=1; full=1 only while cnt=9.
2. WIDTH=4, MAX=9, SATURATE=1: from cnt=0, en=1 up=0 -> cnt holds 0, unf=1, tc pulses once. Continue down for 3 cycles -> tc pulses each cycle and cnt stays 0.
3. ld=1 ld_val=15 with MAX=9 -> cnt=9, full=1, tc=0. Next cycle ld=1 ld_val=3 together with en=1 up=1 -> cnt=3 (load wins).
4. Count to cnt=7, assert clr together with en=1 -> cnt=0, ovf/unf=0, tc=0 next cycle, empty=1. Repeat using rst instead of clr -> identical result.
5. Default parameters (WIDTH=4, MAX=15): alternate up/down around 0 and 15, with en toggling every other cycle -> cnt tracks a reference model, and holds exactly on en=0 cycles.
6. PARAM_COUNTER_PRESCALE_EN defined, PRESCALE=4: 12 enabled cycles, with en dropped for 2 cycles mid-run -> cnt=3. ld mid-run resets the prescaler phase, so the next step occurs 4 enabled cycles after the ld.

Source files
------------

// File: rtl/param_counter_pkg.sv
// Shared types, helpers and parameter legality checks for param_counter.
package param_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int unsigned MIN_WIDTH    = 2;
    localparam int unsigned MAX_WIDTH    = 32;
    localparam int unsigned MIN_PRESCALE = 2;

    // Clamp a load value to the terminal count so nothing above MAX is stored.
    function automatic int unsigned clamp_val(input int unsigned val, input int unsigned max);
        return (val > max) ? max : val;
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
    endfunction

    function automatic bit max_ok(input int unsigned width, input int unsigned max);
        longint unsigned lim;
        lim = (64'(1) << width) - 64'(1);
        return (max >= 1) && (64'(max) <= lim);
    endfunction

    function automatic bit prescale_ok(input int unsigned prescale);
        return prescale >= MIN_PRESCALE;
    endfunction

endpackage

// File: rtl/param_counter_count_bound_detect.sv
// Combinational boundary decode of the registered count against zero and MAX.
module count_bound_detect
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] cnt_i,
    output logic             at_max_o,
    output logic             at_zero_o
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    assign at_max_o  = (cnt_i == MAX_W);
    assign at_zero_o = (cnt_i == '0);

endmodule

// File: rtl/param_counter.sv
// Parametrised up/down counter with load, clear, wrap/saturate and sticky flags.
// Optional prescaler enabled by defining PARAM_COUNTER_PRESCALE_EN.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic             full,
    output logic             empty,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam mode_e            MODE  = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    generate
        if (!width_ok(WIDTH) || !max_ok(WIDTH, MAX) || !prescale_ok(PRESCALE)) begin : g_cfg_err
            $error("param_counter: illegal WIDTH/MAX/PRESCALE configuration");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_max, at_zero;
    logic             step;
    logic [WIDTH-1:0] ld_clamped;

    count_bound_detect #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_bound (
        .cnt_i     (cnt_q),
        .at_max_o  (at_max),
        .at_zero_o (at_zero)
    );

`ifdef PARAM_COUNTER_PRESCALE_EN
    localparam int unsigned PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Only enabled cycles advance the phase; load and clear restart it.
    always_comb begin
        pre_d = pre_q;
        step  = 1'b0;
        if (clr || ld) begin
            pre_d = '0;
        end else if (en) begin
            if (pre_q == PRE_W'(PRESCALE - 1)) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = en;
`endif

    assign ld_clamped = WIDTH'(clamp_val(32'(ld_val), MAX));

    // Next-state: clr > ld > step; tc defaults low so it is a single-cycle pulse.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (ld) begin
            cnt_d = ld_clamped;
        end else if (step) begin
            if (up) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    tc_d  = 1'b1;
                    cnt_d = (MODE == MODE_SAT) ? cnt_q : '0;
                end else begin
                    cnt_d = WIDTH'({1'b0, cnt_q} + (WIDTH + 1)'(1));
                end
            end else begin
                if (at_zero) begin
                    unf_d = 1'b1;
                    tc_d  = 1'b1;
                    cnt_d = (MODE == MODE_SAT) ? cnt_q : MAX_W;
                end else begin
                    cnt_d = WIDTH'({1'b0, cnt_q} - (WIDTH + 1)'(1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cnt   = cnt_q;
    assign full  = at_max;
    assign empty = at_zero;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three configurations on shared stimulus vs a behavioural model.
module tb_param_counter;

`ifdef PARAM_COUNTER_PRESCALE_EN
    localparam int STEP_CYC = 4;
    localparam bit PRE_ON   = 1'b1;
`else
    localparam int STEP_CYC = 1;
    localparam bit PRE_ON   = 1'b0;
`endif
    localparam int PS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] ld_val = 4'd0;
    logic       en  = 1'b0;
    logic       up  = 1'b1;

    logic [2:0][3:0] cnt_v;
    logic [2:0]      full_v, empty_v, tc_v, ovf_v, unf_v;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt[3];
    int m_pre[3];
    bit m_tc[3], m_ovf[3], m_unf[3];
    int max_v[3];
    bit sat_v[3];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(PS)) u_wrap9 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .up(up),
        .cnt(cnt_v[0]), .full(full_v[0]), .empty(empty_v[0]), .tc(tc_v[0]), .ovf(ovf_v[0]), .unf(unf_v[0]));

    param_counter #(.WIDTH(4), .MAX(9), .SATURATE(1), .PRESCALE(PS)) u_sat9 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .up(up),
        .cnt(cnt_v[1]), .full(full_v[1]), .empty(empty_v[1]), .tc(tc_v[1]), .ovf(ovf_v[1]), .unf(unf_v[1]));

    param_counter #(.WIDTH(4), .PRESCALE(PS)) u_def (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .up(up),
        .cnt(cnt_v[2]), .full(full_v[2]), .empty(empty_v[2]), .tc(tc_v[2]), .ovf(ovf_v[2]), .unf(unf_v[2]));

    // Advance the reference model by one edge from the current inputs, then clock the DUTs.
    task automatic clock_edge();
        bit stepping;
        for (int k = 0; k < 3; k++) begin
            if (rst || clr) begin
                m_cnt[k] = 0; m_pre[k] = 0;
                m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end else if (ld) begin
                m_cnt[k] = (int'(ld_val) > max_v[k]) ? max_v[k] : int'(ld_val);
                m_tc[k]  = 0;
                m_pre[k] = 0;
            end else if (en) begin
                m_tc[k]  = 0;
                stepping = 1'b1;
                if (PRE_ON) begin
                    m_pre[k] = m_pre[k] + 1;
                    if (m_pre[k] == PS) m_pre[k] = 0;
                    else stepping = 1'b0;
                end
                if (stepping) begin
                    if (up) begin
                        if (m_cnt[k] == max_v[k]) begin
                            m_ovf[k] = 1; m_tc[k] = 1;
                            if (!sat_v[k]) m_cnt[k] = 0;
                        end else m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        if (m_cnt[k] == 0) begin
                            m_unf[k] = 1; m_tc[k] = 1;
                            if (!sat_v[k]) m_cnt[k] = max_v[k];
                        end else m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end else begin
                m_tc[k] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr = 0; ld = 0; en = 0; up = 1; ld_val = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1; clock_edge(); clock_edge();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (cnt_v[k] !== 4'd0 || full_v[k] !== 1'b0 || empty_v[k] !== 1'b1 ||
                tc_v[k] !== 1'b0 || ovf_v[k] !== 1'b0 || unf_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d got cnt=%0d f=%b e=%b tc=%b o=%b u=%b exp cnt=0 f=0 e=1 tc=0 o=0 u=0",
                         k, cnt_v[k], full_v[k], empty_v[k], tc_v[k], ovf_v[k], unf_v[k]);
            end
        end
    endtask

    task automatic test_wrap();
        rst = 1; clock_edge(); idle_inputs();
        en = 1; up = 1;
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < STEP_CYC; c++) begin
                clock_edge();
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (cnt_v[k] !== 4'(m_cnt[k]) || full_v[k] !== (m_cnt[k] == max_v[k]) ||
                        empty_v[k] !== (m_cnt[k] == 0) || tc_v[k] !== m_tc[k] ||
                        ovf_v[k] !== m_ovf[k] || unf_v[k] !== m_unf[k]) begin
                        n_fail++;
                        $display("FAIL wrap_model dut%0d got cnt=%0d f=%b e=%b tc=%b o=%b u=%b exp cnt=%0d tc=%b o=%b u=%b",
                                 k, cnt_v[k], full_v[k], empty_v[k], tc_v[k], ovf_v[k], unf_v[k],
                                 m_cnt[k], m_tc[k], m_ovf[k], m_unf[k]);
                    end
                end
            end
            if (s == 8) begin
                n_checks++;
                if (cnt_v[0] !== 4'd9 || full_v[0] !== 1'b1 || tc_v[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_at_max got cnt=%0d full=%b tc=%b exp cnt=9 full=1 tc=0", cnt_v[0], full_v[0], tc_v[0]);
                end
            end
            if (s == 9) begin
                n_checks++;
                if (cnt_v[0] !== 4'd0 || tc_v[0] !== 1'b1 || ovf_v[0] !== 1'b1 || full_v[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_to_zero got cnt=%0d tc=%b ovf=%b full=%b exp cnt=0 tc=1 ovf=1 full=0",
                             cnt_v[0], tc_v[0], ovf_v[0], full_v[0]);
                end
            end
        end
        idle_inputs(); clock_edge();
        n_checks++;
        if (tc_v[0] !== 1'b0 || cnt_v[0] !== 4'd0 || ovf_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_tc_one_cycle got tc=%b cnt=%0d ovf=%b exp tc=0 cnt=0 ovf=1", tc_v[0], cnt_v[0], ovf_v[0]);
        end
    endtask

    task automatic test_saturate();
        rst = 1; clock_edge(); idle_inputs();
        en = 1; up = 0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < STEP_CYC; c++) begin
                clock_edge();
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (cnt_v[k] !== 4'(m_cnt[k]) || tc_v[k] !== m_tc[k] ||
                        ovf_v[k] !== m_ovf[k] || unf_v[k] !== m_unf[k] || empty_v[k] !== (m_cnt[k] == 0)) begin
                        n_fail++;
                        $display("FAIL sat_model dut%0d got cnt=%0d tc=%b o=%b u=%b exp cnt=%0d tc=%b o=%b u=%b",
                                 k, cnt_v[k], tc_v[k], ovf_v[k], unf_v[k], m_cnt[k], m_tc[k], m_ovf[k], m_unf[k]);
                    end
                end
            end
            n_checks++;
            if (cnt_v[1] !== 4'd0 || tc_v[1] !== 1'b1 || unf_v[1] !== 1'b1 || empty_v[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_hold_zero step%0d got cnt=%0d tc=%b unf=%b empty=%b exp cnt=0 tc=1 unf=1 empty=1",
                         s, cnt_v[1], tc_v[1], unf_v[1], empty_v[1]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_load();
        rst = 1; clock_edge(); idle_inputs();
        ld = 1; ld_val = 4'd15;
        clock_edge();
        n_checks++;
        if (cnt_v[1] !== 4'd9 || full_v[1] !== 1'b1 || tc_v[1] !== 1'b0 || cnt_v[2] !== 4'd15) begin
            n_fail++;
            $display("FAIL load_clamp got cnt9=%0d full=%b tc=%b cnt15=%0d exp 9 1 0 15", cnt_v[1], full_v[1], tc_v[1], cnt_v[2]);
        end
        ld_val = 4'd3; en = 1; up = 1;
        clock_edge();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (cnt_v[k] !== 4'd3 || tc_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL load_wins dut%0d got cnt=%0d tc=%b ovf=%b exp cnt=3 tc=0 ovf=0", k, cnt_v[k], tc_v[k], ovf_v[k]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1; clock_edge(); idle_inputs();
            en = 1; up = 0;
            for (int c = 0; c < STEP_CYC; c++) clock_edge();
            idle_inputs(); ld = 1; ld_val = 4'd0; clock_edge();
            ld = 0; en = 1; up = 1;
            for (int c = 0; c < 7 * STEP_CYC; c++) clock_edge();
            n_checks++;
            if (cnt_v[2] !== 4'd7 || unf_v[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_setup pass%0d got cnt=%0d unf=%b exp cnt=7 unf=1", pass, cnt_v[2], unf_v[2]);
            end
            if (pass == 0) clr = 1; else rst = 1;
            clock_edge();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (cnt_v[k] !== 4'd0 || ovf_v[k] !== 1'b0 || unf_v[k] !== 1'b0 ||
                    tc_v[k] !== 1'b0 || empty_v[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clear pass%0d dut%0d got cnt=%0d o=%b u=%b tc=%b e=%b exp cnt=0 o=0 u=0 tc=0 e=1",
                             pass, k, cnt_v[k], ovf_v[k], unf_v[k], tc_v[k], empty_v[k]);
                end
            end
            idle_inputs();
        end
        // A tc pulse in flight is cancelled by clr.
        ld = 1; ld_val = 4'd9; clock_edge();
        ld = 0; en = 1; up = 1;
        for (int c = 0; c < STEP_CYC; c++) clock_edge();
        clr = 1; clock_edge();
        n_checks++;
        if (tc_v[0] !== 1'b0 || ovf_v[0] !== 1'b0 || cnt_v[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_cancels_tc got tc=%b ovf=%b cnt=%0d exp tc=0 ovf=0 cnt=0", tc_v[0], ovf_v[0], cnt_v[0]);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit dir;
        dir = 1'b1;
        rst = 1; clock_edge(); idle_inputs();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) dir = ~dir;
            en     = (i % 2 == 0);
            up     = dir;
            ld     = ($urandom_range(0, 19) == 0);
            ld_val = 4'($urandom);
            clr    = ($urandom_range(0, 59) == 0);
            rst    = ($urandom_range(0, 119) == 0);
            clock_edge();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (cnt_v[k] !== 4'(m_cnt[k]) || full_v[k] !== (m_cnt[k] == max_v[k]) ||
                    empty_v[k] !== (m_cnt[k] == 0) || tc_v[k] !== m_tc[k] ||
                    ovf_v[k] !== m_ovf[k] || unf_v[k] !== m_unf[k]) begin
                    n_fail++;
                    $display("FAIL random cyc%0d dut%0d got cnt=%0d f=%b e=%b tc=%b o=%b u=%b exp cnt=%0d tc=%b o=%b u=%b",
                             i, k, cnt_v[k], full_v[k], empty_v[k], tc_v[k], ovf_v[k], unf_v[k],
                             m_cnt[k], m_tc[k], m_ovf[k], m_unf[k]);
                end
            end
        end
        idle_inputs();
    endtask

`ifdef PARAM_COUNTER_PRESCALE_EN
    task automatic test_prescale();
        rst = 1; clock_edge(); idle_inputs();
        up = 1;
        for (int c = 0; c < 14; c++) begin
            en = !(c == 6 || c == 7);
            clock_edge();
        end
        en = 0;
        n_checks++;
        if (cnt_v[2] !== 4'd3) begin
            n_fail++;
            $display("FAIL prescale_count got cnt=%0d exp 3", cnt_v[2]);
        end
        en = 1; clock_edge(); clock_edge();
        en = 0; ld = 1; ld_val = 4'd5; clock_edge();
        ld = 0; en = 1;
        for (int c = 0; c < 3; c++) clock_edge();
        n_checks++;
        if (cnt_v[2] !== 4'd5) begin
            n_fail++;
            $display("FAIL prescale_ld_phase got cnt=%0d exp 5", cnt_v[2]);
        end
        clock_edge();
        n_checks++;
        if (cnt_v[2] !== 4'd6) begin
            n_fail++;
            $display("FAIL prescale_after_ld got cnt=%0d exp 6", cnt_v[2]);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        max_v[0] = 9;  sat_v[0] = 1'b0;
        max_v[1] = 9;  sat_v[1] = 1'b1;
        max_v[2] = 15; sat_v[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end
        test_reset();
        test_wrap();
        test_saturate();
        test_load();
        test_clear();
        test_random();
`ifdef PARAM_COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
